// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a commanded burst from a registered-read FIFO into a valid/ready stream
// Ports:
//   clk, reset_n           clock (posedge), asynchronous active-low reset
//   start, burst_len       1-cycle burst command, accepted only when idle, and its word count
//   fifo_empty, fifo_data  FIFO empty flag and read data (valid the cycle after a read)
//   fifo_rd_en             FIFO read strobe (combinational)
//   m_valid, m_data        output word stream
//   m_last                 marks the final word of the burst
//   m_ready                sink accepts when m_valid && m_ready
//   busy, done             burst in progress / 1-cycle completion pulse
module fifo_burst_reader #(
   parameter int DATA_SIZE = 8,
   parameter int LEN_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [LEN_W-1:0]     burst_len,
   input  logic                 fifo_empty,
   input  logic [DATA_SIZE-1:0] fifo_data,
   output logic                 fifo_rd_en,
   output logic                 m_valid,
   output logic [DATA_SIZE-1:0] m_data,
   output logic                 m_last,
   input  logic                 m_ready,
   output logic                 busy,
   output logic                 done
);
   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;
   state_t               state, state_nxt;
   logic [LEN_W-1:0]     len_q, issued_cnt, sent_cnt;
   logic [1:0]           occ;
   logic [DATA_SIZE-1:0] head_q, tail_q;
   logic                 inflight, go, pop, push, shift, wr_head, wr_tail;
   assign go      = (state == IDLE) && start;
   assign pop     = m_valid && m_ready;
   assign push    = inflight;
   assign m_valid = (occ != 2'd0);
   assign m_data  = head_q;
   assign m_last  = m_valid && (sent_cnt == len_q - LEN_W'(1));
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   // A word already in flight reserves a slot, so the 2-entry buffer can never overflow.
   assign fifo_rd_en = (state == READ) && !fifo_empty &&
                       ({1'b0, occ} + {2'b00, inflight} - {2'b00, pop} < 3'd2);
   // Head is refilled from the tail on a pop of a full buffer, otherwise straight from the FIFO.
   assign shift   = pop && (occ == 2'd2);
   assign wr_head = push && ((occ == 2'd0) || (occ == 2'd1 && pop));
   assign wr_tail = push && ((occ == 2'd1 && !pop) || (occ == 2'd2 && pop));
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (burst_len != '0) ? READ : DONE;
         READ:    if (fifo_rd_en && issued_cnt == len_q - LEN_W'(1)) state_nxt = FLUSH;
         FLUSH:   if (pop && m_last) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         len_q      <= '0;
         issued_cnt <= '0;
         sent_cnt   <= '0;
         occ        <= 2'd0;
         inflight   <= 1'b0;
         head_q     <= '0;
         tail_q     <= '0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_rd_en;
         occ      <= occ + {1'b0, push} - {1'b0, pop};
         if (go) begin
            len_q      <= burst_len;
            issued_cnt <= '0;
            sent_cnt   <= '0;
         end else begin
            if (fifo_rd_en) issued_cnt <= issued_cnt + LEN_W'(1);
            if (pop) sent_cnt <= sent_cnt + LEN_W'(1);
         end
         if (shift) head_q <= tail_q;
         else if (wr_head) head_q <= fifo_data;
         if (wr_tail) tail_q <= fifo_data;
      end
   end
   assert property (@(posedge clk) disable iff (!reset_n) !(push && occ == 2'd2 && !pop));
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader: randomized scenario bench for fifo_burst_reader against a queue-based FIFO and stream model
module tb_fifo_burst_reader;
   localparam int DW = 8;
   localparam int LW = 8;
   logic          clk = 1'b0, reset_n = 1'b0, start = 1'b0, m_ready = 1'b0;
   logic [LW-1:0] burst_len = '0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data = '0;
   logic          fifo_rd_en, m_valid, m_last, busy, done;
   logic [DW-1:0] m_data;
   logic          wr_en = 1'b0, fifo_clr = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] fq[$];
   int            rd_cnt = 0;
   int            vec = 0, errs = 0;
   logic [DW-1:0] exp_q[$], inj_q[$], got_d[$];
   logic          got_l[$];
   int            got_c[$];
   int            done_cnt, busy_cnt, hold_err, empty_rd, done_cyc;

   always #5 clk = ~clk;

   fifo_burst_reader #(.DATA_SIZE(DW), .LEN_W(LW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .burst_len(burst_len),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
      .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
      .busy(busy), .done(done)
   );

   // Behavioural 16x8 FIFO: registered read data, held between reads.
   always @(posedge clk) begin
      if (fifo_clr) fq.delete();
      else begin
         if (fifo_rd_en) begin
            rd_cnt <= rd_cnt + 1;
            if (fq.size() > 0) fifo_data <= fq.pop_front();
         end
         if (wr_en) fq.push_back(wr_data);
      end
      fifo_empty <= (fq.size() == 0);
   end

   task automatic clear_caps();
      got_d.delete(); got_l.delete(); got_c.delete();
      done_cnt = 0; busy_cnt = 0; hold_err = 0; empty_rd = 0; done_cyc = -1;
   endtask

   task automatic preload();
      @(negedge clk); fifo_clr = 1'b1;
      @(negedge clk); fifo_clr = 1'b0;
      foreach (exp_q[i]) begin
         wr_en = 1'b1; wr_data = exp_q[i];
         @(negedge clk);
      end
      wr_en = 1'b0;
   endtask

   task automatic rand_words(input int n);
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(DW'($urandom));
   endtask

   task automatic start_burst(input int len);
      @(negedge clk); start = 1'b1; burst_len = LW'(len);
   endtask

   // Runs cycles, driving m_ready/start/late writes and recording what the sink observes.
   task automatic drain(input int max_c, input int rmode, input int inj_at, input int restart_at, output bit fin);
      logic pv, pl;
      logic [DW-1:0] pd;
      pv = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
      for (int c = 0; c < max_c && !fin; c++) begin
         @(negedge clk);
         start = (c == restart_at);
         if (c == restart_at) burst_len = LW'(9);
         m_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
         wr_en = (inj_at >= 0 && c >= inj_at && inj_q.size() > 0);
         if (wr_en) wr_data = inj_q.pop_front();
         #1;
         if (pv && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) hold_err++;
         pv = m_valid && !m_ready; pd = m_data; pl = m_last;
         if (fifo_rd_en && fifo_empty) empty_rd++;
         if (busy) busy_cnt++;
         if (m_valid && m_ready) begin
            got_d.push_back(m_data); got_l.push_back(m_last); got_c.push_back(c);
         end
         if (done) begin done_cnt++; done_cyc = c; fin = 1'b1; end
      end
      start = 1'b0; wr_en = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vec++;
      if ({fifo_rd_en, m_valid, m_last, busy, done, m_data} !== '0) begin
         errs++; $display("FAIL reset_async got rd/v/l/b/d/data=%b%b%b%b%b/%h need all 0", fifo_rd_en, m_valid, m_last, busy, done, m_data);
      end
      repeat (2) @(negedge clk);
      #1;
      vec++;
      if ({fifo_rd_en, m_valid, m_last, busy, done, m_data} !== '0) begin
         errs++; $display("FAIL reset_clocked got rd/v/l/b/d/data=%b%b%b%b%b/%h need all 0", fifo_rd_en, m_valid, m_last, busy, done, m_data);
      end
      @(negedge clk); reset_n = 1'b1;
   endtask

   task automatic test_basic();
      bit fin; int r0;
      exp_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      preload(); clear_caps(); r0 = rd_cnt;
      start_burst(5); drain(40, 0, -1, -1, fin);
      vec++; if (!fin) begin errs++; $display("FAIL basic_done got none need pulse"); end
      vec++; if (got_d.size() != 5) begin errs++; $display("FAIL basic_count got %0d need 5", got_d.size()); end
      foreach (got_d[i]) begin
         vec++; if (got_d[i] !== exp_q[i]) begin errs++; $display("FAIL basic_data[%0d] got %h need %h", i, got_d[i], exp_q[i]); end
         vec++; if (got_l[i] !== (i == 4)) begin errs++; $display("FAIL basic_last[%0d] got %b need %b", i, got_l[i], i == 4); end
      end
      if (got_c.size() == 5) begin
         vec++; if (got_c[0] != 2) begin errs++; $display("FAIL basic_latency got cycle %0d need 2", got_c[0]); end
         vec++; if (got_c[4] - got_c[0] != 4) begin errs++; $display("FAIL basic_throughput got span %0d need 4", got_c[4] - got_c[0]); end
         vec++; if (done_cyc != got_c[4] + 1) begin errs++; $display("FAIL basic_done_time got %0d need %0d", done_cyc, got_c[4] + 1); end
      end
      vec++; if (rd_cnt - r0 != 5) begin errs++; $display("FAIL basic_reads got %0d need 5", rd_cnt - r0); end
      vec++; if (hold_err + empty_rd != 0) begin errs++; $display("FAIL basic_protocol got %0d/%0d need 0/0", hold_err, empty_rd); end
      @(negedge clk); #1;
      vec++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL basic_idle got busy=%b done=%b need 0 0", busy, done); end
   endtask

   task automatic test_zero_len();
      bit fin; int r0;
      rand_words(3); preload(); clear_caps(); r0 = rd_cnt;
      start_burst(0); drain(10, 0, -1, -1, fin);
      repeat (3) begin
         @(negedge clk); #1;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      vec++; if (done_cnt != 1) begin errs++; $display("FAIL zero_done got %0d pulses need 1", done_cnt); end
      vec++; if (busy_cnt != 1) begin errs++; $display("FAIL zero_busy got %0d cycles need 1", busy_cnt); end
      vec++; if (rd_cnt - r0 != 0 || got_d.size() != 0) begin errs++; $display("FAIL zero_reads got rd=%0d words=%0d need 0 0", rd_cnt - r0, got_d.size()); end
   endtask

   task automatic test_ready_toggle();
      bit fin; int r0;
      rand_words(16); preload(); clear_caps(); r0 = rd_cnt;
      start_burst(16); drain(120, 1, -1, -1, fin);
      vec++; if (!fin || got_d.size() != 16) begin errs++; $display("FAIL toggle_count got fin=%b words=%0d need 1 16", fin, got_d.size()); end
      foreach (got_d[i]) begin
         vec++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 15)) begin
            errs++; $display("FAIL toggle_word[%0d] got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_q[i], i == 15);
         end
      end
      vec++; if (hold_err != 0) begin errs++; $display("FAIL toggle_hold got %0d changes need 0", hold_err); end
      vec++; if (rd_cnt - r0 != 16) begin errs++; $display("FAIL toggle_reads got %0d need 16", rd_cnt - r0); end
   endtask

   task automatic test_fifo_stall();
      bit fin; int r0;
      logic [DW-1:0] want[$];
      rand_words(2); preload(); clear_caps(); r0 = rd_cnt;
      inj_q = {8'hA3, 8'hA4};
      want = {exp_q[0], exp_q[1], 8'hA3, 8'hA4};
      start_burst(4); drain(80, 0, 14, -1, fin);
      vec++; if (!fin || got_d.size() != 4) begin errs++; $display("FAIL stall_count got fin=%b words=%0d need 1 4", fin, got_d.size()); end
      foreach (got_d[i]) begin
         vec++; if (got_d[i] !== want[i] || got_l[i] !== (i == 3)) begin
            errs++; $display("FAIL stall_word[%0d] got %h/%b need %h/%b", i, got_d[i], got_l[i], want[i], i == 3);
         end
      end
      if (got_c.size() == 4) begin
         vec++; if (got_c[2] <= 14) begin errs++; $display("FAIL stall_resume got cycle %0d need >14", got_c[2]); end
      end
      vec++; if (empty_rd != 0) begin errs++; $display("FAIL stall_rd_empty got %0d reads need 0", empty_rd); end
      vec++; if (rd_cnt - r0 != 4) begin errs++; $display("FAIL stall_reads got %0d need 4", rd_cnt - r0); end
   endtask

   task automatic test_reset_midburst();
      bit fin; int r0;
      rand_words(5); preload(); clear_caps();
      start_burst(5); drain(1, 0, -1, -1, fin);
      @(posedge clk); #2; reset_n = 1'b0; #1;
      vec++;
      if ({fifo_rd_en, m_valid, m_last, busy, done, m_data} !== '0) begin
         errs++; $display("FAIL midreset_out got rd/v/l/b/d/data=%b%b%b%b%b/%h need all 0", fifo_rd_en, m_valid, m_last, busy, done, m_data);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rand_words(3); preload(); clear_caps(); r0 = rd_cnt;
      start_burst(3); drain(40, 0, -1, -1, fin);
      vec++; if (!fin || got_d.size() != 3) begin errs++; $display("FAIL midreset_count got fin=%b words=%0d need 1 3", fin, got_d.size()); end
      foreach (got_d[i]) begin
         vec++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == 2)) begin
            errs++; $display("FAIL midreset_word[%0d] got %h/%b need %h/%b", i, got_d[i], got_l[i], exp_q[i], i == 2);
         end
      end
      vec++; if (rd_cnt - r0 != 3) begin errs++; $display("FAIL midreset_reads got %0d need 3", rd_cnt - r0); end
   endtask

   task automatic test_restart_ignored();
      bit fin; int r0;
      rand_words(8); preload(); clear_caps(); r0 = rd_cnt;
      start_burst(4); drain(40, 0, -1, 3, fin);
      repeat (4) begin
         @(negedge clk); #1;
         if (busy) busy_cnt++;
         if (done) done_cnt++;
      end
      vec++; if (got_d.size() != 4 || done_cnt != 1) begin errs++; $display("FAIL restart_count got words=%0d done=%0d need 4 1", got_d.size(), done_cnt); end
      vec++; if (done_cyc != 6) begin errs++; $display("FAIL restart_done_time got %0d need 6", done_cyc); end
      vec++; if (busy_cnt != 7) begin errs++; $display("FAIL restart_busy got %0d cycles need 7", busy_cnt); end
      vec++; if (rd_cnt - r0 != 4) begin errs++; $display("FAIL restart_reads got %0d need 4", rd_cnt - r0); end
   endtask

   task automatic test_random();
      bit fin; int r0, len;
      for (int t = 0; t < 8; t++) begin
         len = $urandom_range(1, 16);
         rand_words($urandom_range(len, 16)); preload(); clear_caps(); r0 = rd_cnt;
         start_burst(len); drain(300, 2, -1, -1, fin);
         vec++; if (!fin || got_d.size() != len) begin errs++; $display("FAIL rand%0d_count got fin=%b words=%0d need 1 %0d", t, fin, got_d.size(), len); end
         foreach (got_d[i]) begin
            vec++; if (got_d[i] !== exp_q[i] || got_l[i] !== (i == len - 1)) begin
               errs++; $display("FAIL rand%0d_word[%0d] got %h/%b need %h/%b", t, i, got_d[i], got_l[i], exp_q[i], i == len - 1);
            end
         end
         if (got_c.size() > 0) begin
            vec++; if (done_cyc != got_c[got_c.size() - 1] + 1) begin errs++; $display("FAIL rand%0d_done_time got %0d need %0d", t, done_cyc, got_c[got_c.size() - 1] + 1); end
         end
         vec++; if (hold_err + empty_rd != 0 || rd_cnt - r0 != len) begin
            errs++; $display("FAIL rand%0d_protocol got hold=%0d rd_empty=%0d reads=%0d need 0 0 %0d", t, hold_err, empty_rd, rd_cnt - r0, len);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_len();
      test_ready_toggle();
      test_fifo_stall();
      test_reset_midburst();
      test_restart_ignored();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
